flash_req_arbiter: RTL and testbench

Shares the single flash `control` sequencer between up to four requesters, for example camera config save, parameter load and host access. Each requester posts an erase, write, read or erase-then-write on a 14-bit row. The block arbitrates round-robin, checks the row region, and issues single-cycle `era`/`wr_flash`/`rd_flash` pulses with a stable `row`. It completes on `toe_done`/`move_done` and returns a per-requester done or error pulse.

---
 rtl/flash_req_arbiter_pkg.sv | 38 +++
 rtl/flash_req_arbiter_if.sv | 33 +++
 rtl/flash_req_arbiter_rr_arbiter.sv | 25 ++
 rtl/flash_req_arbiter.sv | 216 +++++++++++++++++++++
 tb/tb_flash_req_arbiter.sv | 374 +++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/flash_req_arbiter_pkg.sv
// Shared flash-access definitions: op codes, legal row regions and arbiter FSM states.
package flash_pkg;

    localparam int ROW_W = 14;

    typedef enum logic [1:0] {
        OP_ERASE       = 2'd0,
        OP_WRITE       = 2'd1,
        OP_READ        = 2'd2,
        OP_ERASE_WRITE = 2'd3
    } op_e;

    localparam logic [2:0] REG_A = 3'd1;
    localparam logic [2:0] REG_B = 3'd2;
    localparam logic [2:0] REG_C = 3'd3;

    typedef enum logic [3:0] {
        IDLE,
        GRANT,
        CHECK,
        ISSUE_ERA,
        WAIT_ERA,
        ISSUE_WR,
        WAIT_WR,
        ISSUE_RD,
        WAIT_RD,
        DONE,
        ERR
    } state_e;

    // Region lives in the top three row bits; everything outside A..C is off-limits.
    function automatic logic row_region_ok(input logic [ROW_W-1:0] r);
        logic [2:0] region;
        region = r[ROW_W-1:ROW_W-3];
        return (region == REG_A) || (region == REG_B) || (region == REG_C);
    endfunction

endpackage

// File: rtl/flash_req_arbiter_if.sv
// Requester handshake plus command/completion link to the flash control sequencer.
interface flash_req_arbiter_if #(
    parameter int NUM_REQ = 3
);
    logic [NUM_REQ-1:0]    req_valid;
    logic [2*NUM_REQ-1:0]  req_op;
    logic [14*NUM_REQ-1:0] req_row;
    logic [NUM_REQ-1:0]    req_ack;
    logic [NUM_REQ-1:0]    req_done;
    logic [NUM_REQ-1:0]    req_err;

    logic                  era;
    logic                  wr_flash;
    logic                  rd_flash;
    logic [13:0]           row;
    logic                  ctrl_busy;
    logic                  toe_done;
    logic                  move_done;

    logic                  arb_busy;
    logic [1:0]            owner;

    modport slave (
        input  req_valid, req_op, req_row, ctrl_busy, toe_done, move_done,
        output req_ack, req_done, req_err, era, wr_flash, rd_flash, row, arb_busy, owner
    );

    modport master (
        output req_valid, req_op, req_row, ctrl_busy, toe_done, move_done,
        input  req_ack, req_done, req_err, era, wr_flash, rd_flash, row, arb_busy, owner
    );

endinterface

// File: rtl/flash_req_arbiter_rr_arbiter.sv
// Combinational round-robin pick: search starts at ptr and wraps; one-hot grant plus index.
module rr_arbiter #(
    parameter int NUM_REQ = 3
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [1:0]         ptr,
    output logic [NUM_REQ-1:0] gnt,
    output logic [1:0]         idx,
    output logic               any
);

    always_comb begin
        gnt = '0;
        idx = 2'd0;
        any = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!any && req[(int'(ptr) + i) % NUM_REQ]) begin
                any = 1'b1;
                gnt[(int'(ptr) + i) % NUM_REQ] = 1'b1;
                idx = 2'((int'(ptr) + i) % NUM_REQ);
            end
        end
    end

endmodule

// File: rtl/flash_req_arbiter.sv
// Round-robin sharing of the flash control sequencer; ack 1 cycle after request, command 4 cycles
// after request once ctrl_busy is low. FLASH_ARB_TIMEOUT_EN adds a wait-state watchdog.
module flash_req_arbiter
    import flash_pkg::*;
#(
    parameter int          NUM_REQ        = 3,
    parameter int          TO_W           = 28,
    parameter int unsigned TIMEOUT_CYCLES = 28'h8000000
) (
    input  logic              clk,
    input  logic              rst_n,
    flash_req_arbiter_if.slave bus
);

    state_e               state_q, state_d;
    op_e                  op_q, op_d;
    logic [13:0]          row_q, row_d;
    logic [1:0]           owner_q, owner_d;
    logic [NUM_REQ-1:0]   owner_oh_q, owner_oh_d;
    logic [1:0]           rr_ptr_q, rr_ptr_d;
    logic [NUM_REQ-1:0]   ack_q, ack_d;
    logic [NUM_REQ-1:0]   done_q, done_d;
    logic [NUM_REQ-1:0]   err_q, err_d;
    logic                 era_q, era_d;
    logic                 wr_q, wr_d;
    logic                 rd_q, rd_d;
    logic                 busy_q, busy_d;

    logic [NUM_REQ-1:0]   gnt_oh;
    logic [1:0]           gnt_idx;
    logic                 gnt_any;
    logic                 cmd_issue;
    logic                 in_wait;
    logic                 to_hit;

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
        .req (bus.req_valid),
        .ptr (rr_ptr_q),
        .gnt (gnt_oh),
        .idx (gnt_idx),
        .any (gnt_any)
    );

    assign cmd_issue = era_d | wr_d | rd_d;
    assign in_wait   = (state_q == WAIT_ERA) || (state_q == WAIT_WR) || (state_q == WAIT_RD);

`ifdef FLASH_ARB_TIMEOUT_EN
    logic [TO_W-1:0] to_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            to_cnt_q <= '0;
        end else if (cmd_issue) begin
            to_cnt_q <= '0;
        end else if (in_wait) begin
            to_cnt_q <= to_cnt_q + 1'b1;
        end
    end

    // Fire on the cycle whose increment would reach the limit so req_err lands exactly then.
    assign to_hit = in_wait && (to_cnt_q == TO_W'(TIMEOUT_CYCLES - 1));
`else
    assign to_hit = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        row_d      = row_q;
        owner_d    = owner_q;
        owner_oh_d = owner_oh_q;
        rr_ptr_d   = rr_ptr_q;
        ack_d      = '0;
        done_d     = '0;
        err_d      = '0;
        era_d      = 1'b0;
        wr_d       = 1'b0;
        rd_d       = 1'b0;
        busy_d     = busy_q;

        case (state_q)
            IDLE: begin
                if (gnt_any) begin
                    state_d    = GRANT;
                    op_d       = op_e'(bus.req_op[2*int'(gnt_idx) +: 2]);
                    row_d      = bus.req_row[14*int'(gnt_idx) +: 14];
                    owner_d    = gnt_idx;
                    owner_oh_d = gnt_oh;
                    ack_d      = gnt_oh;
                    busy_d     = 1'b1;
                    rr_ptr_d   = (gnt_idx == 2'(NUM_REQ - 1)) ? 2'd0 : gnt_idx + 2'd1;
                end
            end
            GRANT: state_d = CHECK;
            CHECK: begin
                if (!row_region_ok(row_q)) begin
                    state_d = ERR;
                end else begin
                    case (op_q)
                        OP_WRITE: state_d = ISSUE_WR;
                        OP_READ:  state_d = ISSUE_RD;
                        default:  state_d = ISSUE_ERA;
                    endcase
                end
            end
            ISSUE_ERA: begin
                if (!bus.ctrl_busy) begin
                    era_d   = 1'b1;
                    state_d = WAIT_ERA;
                end
            end
            ISSUE_WR: begin
                if (!bus.ctrl_busy) begin
                    wr_d    = 1'b1;
                    state_d = WAIT_WR;
                end
            end
            ISSUE_RD: begin
                if (!bus.ctrl_busy) begin
                    rd_d    = 1'b1;
                    state_d = WAIT_RD;
                end
            end
            WAIT_ERA: begin
                if (bus.toe_done) begin
                    if (op_q == OP_ERASE_WRITE) begin
                        state_d = ISSUE_WR;
                    end else begin
                        done_d  = owner_oh_q;
                        busy_d  = 1'b0;
                        state_d = DONE;
                    end
                end else if (to_hit) begin
                    err_d   = owner_oh_q;
                    busy_d  = 1'b0;
                    state_d = ERR;
                end
            end
            WAIT_WR: begin
                if (bus.toe_done) begin
                    done_d  = owner_oh_q;
                    busy_d  = 1'b0;
                    state_d = DONE;
                end else if (to_hit) begin
                    err_d   = owner_oh_q;
                    busy_d  = 1'b0;
                    state_d = ERR;
                end
            end
            WAIT_RD: begin
                if (bus.move_done) begin
                    done_d  = owner_oh_q;
                    busy_d  = 1'b0;
                    state_d = DONE;
                end else if (to_hit) begin
                    err_d   = owner_oh_q;
                    busy_d  = 1'b0;
                    state_d = ERR;
                end
            end
            DONE: state_d = IDLE;
            ERR: begin
                // A timeout already raised req_err on entry; a bad region raises it here.
                if (err_q == '0) begin
                    err_d  = owner_oh_q;
                    busy_d = 1'b0;
                end
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            op_q       <= OP_ERASE;
            row_q      <= '0;
            owner_q    <= '0;
            owner_oh_q <= '0;
            rr_ptr_q   <= '0;
            ack_q      <= '0;
            done_q     <= '0;
            err_q      <= '0;
            era_q      <= 1'b0;
            wr_q       <= 1'b0;
            rd_q       <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            row_q      <= row_d;
            owner_q    <= owner_d;
            owner_oh_q <= owner_oh_d;
            rr_ptr_q   <= rr_ptr_d;
            ack_q      <= ack_d;
            done_q     <= done_d;
            err_q      <= err_d;
            era_q      <= era_d;
            wr_q       <= wr_d;
            rd_q       <= rd_d;
            busy_q     <= busy_d;
        end
    end

    assign bus.req_ack  = ack_q;
    assign bus.req_done = done_q;
    assign bus.req_err  = err_q;
    assign bus.era      = era_q;
    assign bus.wr_flash = wr_q;
    assign bus.rd_flash = rd_q;
    assign bus.row      = row_q;
    assign bus.owner    = owner_q;
    assign bus.arb_busy = busy_q;

endmodule

// File: tb/tb_flash_req_arbiter.sv
// Directed bench for flash_req_arbiter; inputs driven and outputs sampled on the falling edge.
module tb_flash_req_arbiter;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    flash_req_arbiter_if #(.NUM_REQ(3)) bus ();

    flash_req_arbiter #(
        .NUM_REQ        (3),
        .TO_W           (28),
        .TIMEOUT_CYCLES (100)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int tests_run = 0;
    int fails     = 0;

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic clear_inputs();
        bus.req_valid = '0;
        bus.req_op    = '0;
        bus.req_row   = '0;
        bus.ctrl_busy = 1'b0;
        bus.toe_done  = 1'b0;
        bus.move_done = 1'b0;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst_n = 1'b0;
        clear_inputs();
        tick(2);
        rst_n = 1'b1;
        tick(1);
    endtask

    task automatic test_reset();
        tick(2);
        tests_run++;
        if ({bus.req_ack, bus.req_done, bus.req_err} !== 9'd0) begin
            fails++; $display("FAIL reset_pulses got=%b exp=0", {bus.req_ack, bus.req_done, bus.req_err});
        end
        tests_run++;
        if ({bus.era, bus.wr_flash, bus.rd_flash} !== 3'b000) begin
            fails++; $display("FAIL reset_cmds got=%b exp=000", {bus.era, bus.wr_flash, bus.rd_flash});
        end
        tests_run++;
        if (bus.row !== 14'h0000 || bus.owner !== 2'd0) begin
            fails++; $display("FAIL reset_row_owner got=%h/%0d exp=0/0", bus.row, bus.owner);
        end
        tests_run++;
        if (bus.arb_busy !== 1'b0) begin
            fails++; $display("FAIL reset_busy got=%b exp=0", bus.arb_busy);
        end
        rst_n = 1'b1;
        tick(3);
        tests_run++;
        if (bus.req_ack !== 3'b000 || bus.arb_busy !== 1'b0) begin
            fails++; $display("FAIL reset_idle ack=%b busy=%b exp=000/0", bus.req_ack, bus.arb_busy);
        end
    endtask

    task automatic test_single_read();
        bus.req_valid     = 3'b010;
        bus.req_op[3:2]   = 2'd2;
        bus.req_row[27:14] = 14'h0900;
        tick(1);
        tests_run++;
        if (bus.req_ack !== 3'b010 || bus.owner !== 2'd1 || bus.arb_busy !== 1'b1) begin
            fails++; $display("FAIL read_ack ack=%b owner=%0d busy=%b exp=010/1/1", bus.req_ack, bus.owner, bus.arb_busy);
        end
        bus.req_valid = 3'b000;
        tick(3);
        tests_run++;
        if (bus.rd_flash !== 1'b1 || bus.row !== 14'h0900 || bus.era !== 1'b0 || bus.wr_flash !== 1'b0) begin
            fails++; $display("FAIL read_cmd rd=%b row=%h era=%b wr=%b exp=1/0900/0/0", bus.rd_flash, bus.row, bus.era, bus.wr_flash);
        end
        tick(1);
        tests_run++;
        if (bus.rd_flash !== 1'b0) begin
            fails++; $display("FAIL read_cmd_width rd=%b exp=0", bus.rd_flash);
        end
        bus.move_done = 1'b1;
        tick(1);
        bus.move_done = 1'b0;
        tests_run++;
        if (bus.req_done !== 3'b010 || bus.req_err !== 3'b000) begin
            fails++; $display("FAIL read_done done=%b err=%b exp=010/000", bus.req_done, bus.req_err);
        end
        tick(1);
        tests_run++;
        if (bus.req_done !== 3'b000 || bus.arb_busy !== 1'b0 || bus.row !== 14'h0900 || bus.owner !== 2'd1) begin
            fails++; $display("FAIL read_after done=%b busy=%b row=%h owner=%0d exp=000/0/0900/1", bus.req_done, bus.arb_busy, bus.row, bus.owner);
        end
    endtask

    task automatic test_contention();
        logic [2:0]  exp_oh [4];
        logic [2:0]  got;
        logic [2:0]  dn;
        logic [13:0] rrow;
        exp_oh = '{3'b001, 3'b010, 3'b100, 3'b001};
        apply_reset();
        for (int i = 0; i < 3; i++) begin
            bus.req_op[2*i +: 2]   = 2'd2;
            bus.req_row[14*i +: 14] = 14'h0800 + 14'(i);
        end
        bus.req_valid = 3'b111;
        for (int it = 0; it < 4; it++) begin
            got = '0;
            for (int c = 0; c < 20; c++) begin
                if (bus.req_ack != 3'b000) begin got = bus.req_ack; break; end
                tick(1);
            end
            tests_run++;
            if (got !== exp_oh[it]) begin
                fails++; $display("FAIL contention_grant[%0d] got=%b exp=%b", it, got, exp_oh[it]);
            end
            bus.req_valid = bus.req_valid & ~got;
            rrow = '0;
            for (int c = 0; c < 20; c++) begin
                if (bus.rd_flash) begin rrow = bus.row; break; end
                tick(1);
            end
            tests_run++;
            if (rrow !== 14'h0800 + 14'(it % 3)) begin
                fails++; $display("FAIL contention_row[%0d] got=%h exp=%h", it, rrow, 14'h0800 + 14'(it % 3));
            end
            bus.move_done = 1'b1;
            tick(1);
            bus.move_done = 1'b0;
            dn = '0;
            for (int c = 0; c < 20; c++) begin
                if (bus.req_done != 3'b000) begin dn = bus.req_done; break; end
                tick(1);
            end
            tests_run++;
            if (dn !== exp_oh[it]) begin
                fails++; $display("FAIL contention_done[%0d] got=%b exp=%b", it, dn, exp_oh[it]);
            end
            if (it == 0) bus.req_valid[0] = 1'b1;
        end
        bus.req_valid = 3'b000;
        tick(2);
    endtask

    task automatic test_erase_write();
        int extra;
        bus.req_valid       = 3'b100;
        bus.req_op[5:4]     = 2'd3;
        bus.req_row[41:28]  = 14'h1000;
        tick(1);
        bus.req_valid = 3'b000;
        tick(3);
        tests_run++;
        if (bus.era !== 1'b1 || bus.wr_flash !== 1'b0 || bus.row !== 14'h1000) begin
            fails++; $display("FAIL ew_era era=%b wr=%b row=%h exp=1/0/1000", bus.era, bus.wr_flash, bus.row);
        end
        tick(1);
        bus.toe_done = 1'b1;
        tick(1);
        bus.toe_done = 1'b0;
        tests_run++;
        if (bus.wr_flash !== 1'b0 || bus.req_done !== 3'b000) begin
            fails++; $display("FAIL ew_gap wr=%b done=%b exp=0/000", bus.wr_flash, bus.req_done);
        end
        tick(1);
        tests_run++;
        if (bus.wr_flash !== 1'b1 || bus.row !== 14'h1000) begin
            fails++; $display("FAIL ew_wr wr=%b row=%h exp=1/1000", bus.wr_flash, bus.row);
        end
        tick(1);
        bus.toe_done = 1'b1;
        tick(1);
        bus.toe_done = 1'b0;
        tests_run++;
        if (bus.req_done !== 3'b100) begin
            fails++; $display("FAIL ew_done got=%b exp=100", bus.req_done);
        end
        extra = 0;
        for (int c = 0; c < 5; c++) begin
            tick(1);
            if (bus.req_done != 3'b000) extra++;
        end
        tests_run++;
        if (extra !== 0) begin
            fails++; $display("FAIL ew_single_done extra=%0d exp=0", extra);
        end
    endtask

    task automatic test_invalid_region();
        logic cmd_seen;
        bus.req_valid      = 3'b001;
        bus.req_op[1:0]    = 2'd1;
        bus.req_row[13:0]  = 14'h2000;
        tick(1);
        bus.req_valid = 3'b000;
        cmd_seen = 1'b0;
        tests_run++;
        if (bus.req_ack !== 3'b001) begin
            fails++; $display("FAIL inv_ack got=%b exp=001", bus.req_ack);
        end
        for (int c = 0; c < 3; c++) begin
            tick(1);
            cmd_seen = cmd_seen | bus.era | bus.wr_flash | bus.rd_flash;
        end
        tests_run++;
        if (bus.req_err !== 3'b001 || bus.req_done !== 3'b000) begin
            fails++; $display("FAIL inv_err err=%b done=%b exp=001/000", bus.req_err, bus.req_done);
        end
        for (int c = 0; c < 3; c++) begin
            tick(1);
            cmd_seen = cmd_seen | bus.era | bus.wr_flash | bus.rd_flash;
        end
        tests_run++;
        if (cmd_seen !== 1'b0) begin
            fails++; $display("FAIL inv_no_cmd got=%b exp=0", cmd_seen);
        end
        tests_run++;
        if (bus.arb_busy !== 1'b0 || bus.req_err !== 3'b000) begin
            fails++; $display("FAIL inv_idle busy=%b err=%b exp=0/000", bus.arb_busy, bus.req_err);
        end
    endtask

    task automatic test_busy_gating();
        logic wr_seen;
        bus.ctrl_busy      = 1'b1;
        bus.req_valid      = 3'b010;
        bus.req_op[3:2]    = 2'd1;
        bus.req_row[27:14] = 14'h1800;
        tick(1);
        bus.req_valid = 3'b000;
        wr_seen = 1'b0;
        for (int c = 0; c < 11; c++) begin
            tick(1);
            wr_seen = wr_seen | bus.wr_flash;
        end
        tests_run++;
        if (wr_seen !== 1'b0) begin
            fails++; $display("FAIL busy_hold wr_seen=%b exp=0", wr_seen);
        end
        bus.ctrl_busy = 1'b0;
        tick(1);
        tests_run++;
        if (bus.wr_flash !== 1'b1 || bus.row !== 14'h1800) begin
            fails++; $display("FAIL busy_release wr=%b row=%h exp=1/1800", bus.wr_flash, bus.row);
        end
        tick(1);
        bus.move_done = 1'b1;
        tick(1);
        bus.move_done = 1'b0;
        tests_run++;
        if (bus.req_done !== 3'b000 || bus.arb_busy !== 1'b1) begin
            fails++; $display("FAIL stray_done done=%b busy=%b exp=000/1", bus.req_done, bus.arb_busy);
        end
        bus.toe_done = 1'b1;
        tick(1);
        bus.toe_done = 1'b0;
        tests_run++;
        if (bus.req_done !== 3'b010) begin
            fails++; $display("FAIL busy_done got=%b exp=010", bus.req_done);
        end
        tick(2);
    endtask

    task automatic test_reset_midop();
        logic lost;
        bus.req_valid      = 3'b100;
        bus.req_op[5:4]    = 2'd0;
        bus.req_row[41:28] = 14'h0800;
        tick(1);
        bus.req_valid = 3'b000;
        tick(3);
        tests_run++;
        if (bus.era !== 1'b1) begin
            fails++; $display("FAIL midrst_era got=%b exp=1", bus.era);
        end
        rst_n = 1'b0;
        tick(1);
        tests_run++;
        if (bus.arb_busy !== 1'b0 || bus.row !== 14'h0000 || bus.owner !== 2'd0) begin
            fails++; $display("FAIL midrst_clear busy=%b row=%h owner=%0d exp=0/0000/0", bus.arb_busy, bus.row, bus.owner);
        end
        rst_n = 1'b1;
        bus.toe_done = 1'b1;
        tick(1);
        bus.toe_done = 1'b0;
        lost = (bus.req_done != 3'b000) || (bus.req_err != 3'b000);
        for (int c = 0; c < 4; c++) begin
            tick(1);
            lost = lost | (bus.req_done != 3'b000) | (bus.req_err != 3'b000);
        end
        tests_run++;
        if (lost !== 1'b0) begin
            fails++; $display("FAIL midrst_no_report got=%b exp=0", lost);
        end
    endtask

`ifdef FLASH_ARB_TIMEOUT_EN
    task automatic test_timeout();
        logic early;
        logic late_done;
        bus.req_valid      = 3'b010;
        bus.req_op[3:2]    = 2'd0;
        bus.req_row[27:14] = 14'h0800;
        tick(1);
        bus.req_valid = 3'b000;
        tick(3);
        tests_run++;
        if (bus.era !== 1'b1) begin
            fails++; $display("FAIL to_era got=%b exp=1", bus.era);
        end
        early = 1'b0;
        for (int c = 0; c < 99; c++) begin
            tick(1);
            early = early | (bus.req_err != 3'b000) | (bus.req_done != 3'b000);
        end
        tests_run++;
        if (early !== 1'b0) begin
            fails++; $display("FAIL to_early got=%b exp=0", early);
        end
        tick(1);
        tests_run++;
        if (bus.req_err !== 3'b010) begin
            fails++; $display("FAIL to_err got=%b exp=010", bus.req_err);
        end
        tick(1);
        bus.toe_done = 1'b1;
        tick(1);
        bus.toe_done = 1'b0;
        late_done = (bus.req_done != 3'b000);
        for (int c = 0; c < 4; c++) begin
            tick(1);
            late_done = late_done | (bus.req_done != 3'b000);
        end
        tests_run++;
        if (late_done !== 1'b0 || bus.arb_busy !== 1'b0) begin
            fails++; $display("FAIL to_late_done done=%b busy=%b exp=0/0", late_done, bus.arb_busy);
        end
    endtask
`endif

    initial begin
        rst_n = 1'b0;
        clear_inputs();
        test_reset();
        test_single_read();
        test_contention();
        test_erase_write();
        test_invalid_region();
        test_busy_gating();
        test_reset_midop();
`ifdef FLASH_ARB_TIMEOUT_EN
        test_timeout();
`endif
        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish tests_run=%0d", tests_run);
        $fatal(1, "watchdog expired");
    end

endmodule
